// File: rtl/tug_field.sv
// tug_field: tug-of-war playfield. A single position register drives a
// one-hot LED row; pushing past either end wins the round and bumps that
// side's saturating tally. restartGame re-centres without touching scores.
module tug_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  restartGame,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  left_win,
  output logic                  right_win,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score
);

  localparam int                    PW     = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0]         CENTER = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]         LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [SCORE_W-1:0]    SMAX   = '1;
  localparam logic [NUM_LIGHTS-1:0] ONE    = NUM_LIGHTS'(1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [PW-1:0]      pos, pos_n;
  logic [SCORE_W-1:0] lsc, lsc_n;
  logic [SCORE_W-1:0] rsc, rsc_n;
  logic               move_l, move_r;

  // State, position and tally registers; reset re-centres and clears scores.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= PLAY;
      pos   <= CENTER;
      lsc   <= '0;
      rsc   <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      lsc   <= lsc_n;
      rsc   <= rsc_n;
    end
  end

  // Next-state: restart wins over moves; simultaneous L and R cancel out.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    lsc_n   = lsc;
    rsc_n   = rsc;
    move_l  = L & ~R;
    move_r  = R & ~L;
    if (restartGame) begin
      state_n = PLAY;
      pos_n   = CENTER;
    end else if (state == PLAY) begin
      if (move_l) begin
        if (pos == LAST) begin
          state_n = WIN_L;
          if (lsc != SMAX) lsc_n = lsc + SCORE_W'(1);
        end else begin
          pos_n = pos + PW'(1);
        end
      end else if (move_r) begin
        if (pos == '0) begin
          state_n = WIN_R;
          if (rsc != SMAX) rsc_n = rsc + SCORE_W'(1);
        end else begin
          pos_n = pos - PW'(1);
        end
      end
    end
  end

  // Outputs decoded purely from registers.
  always_comb begin
    leds        = (state == PLAY) ? (ONE << pos) : '0;
    left_win    = (state == WIN_L);
    right_win   = (state == WIN_R);
    left_score  = lsc;
    right_score = rsc;
  end

endmodule
